conv_mac_pipe: RTL

CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_tap_tree.sv | 39 +++
 rtl/conv_mac_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared FSM state type, drain length and accumulator-width helper for the
// convolution MAC pipeline.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESULT = 2'd2
  } conv_state_e;

  localparam int DRAIN_CYCLES = 2;

  // Wide enough that summing taps*chans full-width products plus bias never overflows.
  function automatic int acc_width(input int bitwidth, input int taps, input int chans);
    return 2 * bitwidth + $clog2(taps * chans + 1);
  endfunction

endpackage

// File: rtl/conv_tap_tree.sv
// Per-tap signed multipliers with fixed-point rescale, the stage-P product
// register and the combinational window adder tree.
module conv_tap_tree
  import conv_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int FRACBITS = 16,
  parameter int TAPS     = 25,
  parameter int ACCW     = acc_width(BITWIDTH, TAPS, 1)
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             load,
  input  logic [TAPS-1:0][BITWIDTH-1:0]    data,
  input  logic [TAPS-1:0][BITWIDTH-1:0]    weight,
  output logic signed [ACCW-1:0]           window_sum
);

  localparam int PW = 2 * BITWIDTH;

  logic signed [PW-1:0] prod_p [TAPS];

  // Full-width product, then arithmetic shift: rounds toward minus infinity.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < TAPS; i++) prod_p[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < TAPS; i++)
        prod_p[i] <= ($signed({{BITWIDTH{data[i][BITWIDTH-1]}}, data[i]}) *
                      $signed({{BITWIDTH{weight[i][BITWIDTH-1]}}, weight[i]})) >>> FRACBITS;
    end
  end

  always_comb begin
    window_sum = '0;
    for (int i = 0; i < TAPS; i++) window_sum = window_sum + ACCW'(prod_p[i]);
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// Multi-channel convolution MAC: tap tree, channel accumulator, drain/result FSM.
// Define CONV_MAC_SATURATE_EN to clamp the result instead of wrapping it.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_ACCUM  | accepting channel beats (in_ready=1)
// ST_DRAIN  | last beat in flight through stage P / stage A, result staged
// ST_RESULT | result held with out_valid=1 until out_ready
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int BITWIDTH     = 32,
  parameter int FRACBITS     = 16,
  parameter int INPUTCHANNEL = 1,
  parameter int FILTERHEIGHT = 5,
  parameter int FILTERWIDTH  = 5
) (
  input  logic                                              Clk,
  input  logic                                              Reset,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [FILTERHEIGHT*FILTERWIDTH-1:0][BITWIDTH-1:0] data,
  input  logic [FILTERHEIGHT*FILTERWIDTH-1:0][BITWIDTH-1:0] weight,
  input  logic signed [BITWIDTH-1:0]                        bias,
  input  logic                                              reluEnable,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic signed [BITWIDTH-1:0]                        result,
  output logic                                              busy
);

  localparam int TAPS = FILTERHEIGHT * FILTERWIDTH;
  localparam int ACCW = acc_width(BITWIDTH, TAPS, INPUTCHANNEL);
  localparam int CW   = (INPUTCHANNEL > 1) ? $clog2(INPUTCHANNEL) : 1;
  localparam int DCW  = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CH = CW'(INPUTCHANNEL - 1);

  conv_state_e state, state_nxt;
  logic [CW-1:0]  ch_cnt;
  logic [DCW-1:0] drain_cnt;
  logic accept, first_beat, last_beat, drain_done;
  logic p_valid, p_first, relu_q;
  logic signed [BITWIDTH-1:0] p_bias;
  logic signed [ACCW-1:0]     window_sum, acc;
  logic [BITWIDTH-1:0]        result_nxt;

  assign accept     = in_valid && in_ready;
  assign first_beat = (ch_cnt == '0);
  assign last_beat  = (ch_cnt == LAST_CH);
  assign drain_done = (state == ST_DRAIN) && (drain_cnt == '0);

  conv_tap_tree #(
    .BITWIDTH (BITWIDTH),
    .FRACBITS (FRACBITS),
    .TAPS     (TAPS),
    .ACCW     (ACCW)
  ) u_tap_tree (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (accept),
    .data       (data),
    .weight     (weight),
    .window_sum (window_sum)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM:  if (accept && last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt == '0)     state_nxt = ST_RESULT;
      ST_RESULT: if (out_ready)           state_nxt = ST_ACCUM;
      default:                            state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_ACCUM);
    out_valid = (state == ST_RESULT);
    busy      = (state != ST_ACCUM) || (ch_cnt != '0);
  end

  // Loaded on the last-beat edge; its terminal count lands after stage A has settled.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                drain_cnt <= '0;
    else if (accept && last_beat)             drain_cnt <= DCW'(DRAIN_CYCLES);
    else if (state == ST_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DCW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ch_cnt  <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_bias  <= '0;
      relu_q  <= 1'b0;
      acc     <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        ch_cnt  <= last_beat ? '0 : ch_cnt + CW'(1);
        p_first <= first_beat;
        p_bias  <= bias;
        if (first_beat) relu_q <= reluEnable;
      end
      if (p_valid) acc <= p_first ? window_sum + ACCW'(p_bias) : acc + window_sum;
    end
  end

`ifdef CONV_MAC_SATURATE_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
`endif

  always_comb begin
    result_nxt = '0;
    if (!(relu_q && acc[ACCW-1])) begin
`ifdef CONV_MAC_SATURATE_EN
      if (acc > SAT_MAX)      result_nxt = SAT_MAX[BITWIDTH-1:0];
      else if (acc < SAT_MIN) result_nxt = SAT_MIN[BITWIDTH-1:0];
      else                    result_nxt = acc[BITWIDTH-1:0];
`else
      result_nxt = acc[BITWIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           result <= '0;
    else if (drain_done) result <= result_nxt;
  end

endmodule
